// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM state codes,
// opcode/funct constants, ALU operation codes and the internal aluop selector.
`timescale 1ns/1ps
package mips_ctrl_pkg;

  // Raw state codes stay visible as plain constants so older blocks that
  // compare against numeric state values keep working.
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  typedef enum logic [3:0] {
    FETCH   = S_FETCH,
    DECODE  = S_DECODE,
    MEMADR  = S_MEMADR,
    MEMRD   = S_MEMRD,
    MEMWB   = S_MEMWB,
    MEMWR   = S_MEMWR,
    RTYPEEX = S_RTYPEEX,
    RTYPEWB = S_RTYPEWB,
    BEQEX   = S_BEQEX,
    ADDIEX  = S_ADDIEX,
    ADDIWB  = S_ADDIWB,
    JEX     = S_JEX
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // An opcode is executable if it is one of the fixed-format instructions,
  // or an R-type whose funct field the ALU decoder recognises.
  function automatic logic op_supported(input logic [5:0] op, input logic funct_valid);
    logic ok;
    case (op)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      OP_RTYPE:                            ok = funct_valid;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's aluop selector and the instruction funct field
// onto the 3-bit ALU operation code.
//   aluop       in  2  ADD / SUB / FUNCT selector from the control FSM
//   funct       in  6  IR[5:0]
//   alucontrol  out 3  ALU operation code
//   funct_valid out 1  funct names a supported R-type operation
`timescale 1ns/1ps
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_valid
);

  logic [2:0] funct_code;

  always_comb begin
    funct_code  = ALU_ADD;
    funct_valid = 1'b0;
    case (funct)
      FUNCT_ADD: begin funct_code = ALU_ADD; funct_valid = 1'b1; end
      FUNCT_SUB: begin funct_code = ALU_SUB; funct_valid = 1'b1; end
      FUNCT_AND: begin funct_code = ALU_AND; funct_valid = 1'b1; end
      FUNCT_OR:  begin funct_code = ALU_OR;  funct_valid = 1'b1; end
      FUNCT_SLT: begin funct_code = ALU_SLT; funct_valid = 1'b1; end
      default:   begin funct_code = ALU_ADD; funct_valid = 1'b0; end
    endcase
  end

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD:   alucontrol = ALU_ADD;
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: alucontrol = funct_code;
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit. Steps the shared datapath through the
// per-instruction state sequence and drives every datapath enable/select.
//   clk, reset_n              clock, async active-low reset
//   op, funct                 IR[31:26], IR[5:0]
//   zero                      ALU zero flag (beq)
//   mem_ready                 memory access completes this cycle
//   pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
//   alusrca, alusrcb, pcsrc   datapath controls
//   alucontrol                ALU operation code
//   illegal                   one-cycle pulse on an unsupported op/funct
//   instr_done                one-cycle pulse in each instruction's final state
//
// state   | meaning
// FETCH   | read instr at PC, PC <= PC+4; waits for mem_ready
// DECODE  | branch target into ALUOut, dispatch on op
// MEMADR  | ALUOut <= A + signimm
// MEMRD   | read data memory at ALUOut; waits for mem_ready
// MEMWB   | rt <= MDR
// MEMWR   | write data memory at ALUOut; waits for mem_ready
// RTYPEEX | ALUOut <= A op B
// RTYPEWB | rd <= ALUOut
// BEQEX   | compare A-B, PC <= ALUOut if zero
// ADDIEX  | ALUOut <= A + signimm
// ADDIWB  | rt <= ALUOut
// JEX     | PC <= jump target
`timescale 1ns/1ps
module mc_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic       instr_done
);

  state_t state_q;
  state_t state_d;
  logic   active_q;
  logic   run;

  aluop_t aluop;
  logic   funct_valid;
  logic   op_legal;

  logic pcwrite;
  logic branch;
  logic irwrite_raw;
  logic memwrite_raw;
  logic regwrite_raw;
  logic done_raw;
  logic illegal_raw;

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct       (funct),
    .alucontrol  (alucontrol),
    .funct_valid (funct_valid)
  );

  assign op_legal = op_supported(op, funct_valid);

  // active_q holds the FSM parked in FETCH with all strobes off until the
  // first rising edge after reset release, so the first real fetch cycle
  // starts cleanly on a clock boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FETCH;
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      state_q  <= active_q ? state_d : FETCH;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = funct_valid ? RTYPEEX : FETCH;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
      RTYPEEX: state_d = RTYPEWB;
      RTYPEWB: state_d = FETCH;
      BEQEX:   state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JEX:     state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = ALUOP_ADD;
    done_raw     = 1'b0;
    illegal_raw  = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcwrite     = mem_ready;
      end
      DECODE: begin
        alusrcb     = 2'b11;
        illegal_raw = ~op_legal;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        iord = 1'b1;
      end
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        done_raw     = mem_ready;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      BEQEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = 2'b01;
        branch   = 1'b1;
        done_raw = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: begin
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      JEX: begin
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        done_raw = 1'b1;
      end
      default: begin
        pcwrite = 1'b0;
      end
    endcase
  end

  // reset_n gates the strobes directly so an in-flight write dies the
  // moment reset asserts, without waiting on the state register.
  assign run        = reset_n & active_q;
  assign pcen       = run & (pcwrite | (branch & zero));
  assign irwrite    = run & irwrite_raw;
  assign memwrite   = run & memwrite_raw;
  assign regwrite   = run & regwrite_raw;
  assign instr_done = run & done_raw;
  assign illegal    = run & illegal_raw;

endmodule
